// File: rtl/sar_ctrl.sv
// Successive-approximation control: sample/hold pulse, one-bit-per-cycle DAC trial code, result strobe.
// Optional: define SAR_TWOS_COMP_EN to present dout in two's complement (MSB of resolved code inverted).
module sar_ctrl #(
  parameter int NBIT  = 8,
  parameter int NSAMP = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            comp,
  output logic            sample,
  output logic [NBIT-1:0] dac_code,
  output logic [NBIT-1:0] dout,
  output logic            valid,
  output logic            busy
);

  localparam int CW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int IW = $clog2(NBIT);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(NSAMP - 1);
  localparam logic [IW-1:0]   IDX_MSB  = IW'(NBIT - 1);
  localparam logic [NBIT-1:0] MIDSCALE = {1'b1, {(NBIT-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONV,
    S_DONE
  } state_e;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic [NBIT-1:0] r_code;
  logic [NBIT-1:0] r_dout;
  logic            r_sample;
  logic            r_valid;
  logic            r_busy;

  state_e          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic [NBIT-1:0] w_code_nxt;
  logic [NBIT-1:0] w_dout_nxt;
  logic [NBIT-1:0] w_trial;
  logic            w_keep;
  logic            w_sample_nxt;
  logic            w_valid_nxt;
  logic            w_busy_nxt;

  function automatic logic [NBIT-1:0] to_dout(input logic [NBIT-1:0] code);
`ifdef SAR_TWOS_COMP_EN
    return {~code[NBIT-1], code[NBIT-2:0]};
`else
    return code;
`endif
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: reset clears the result register as well, so a conversion
      // interrupted by reset never leaves a stale or partial dout behind.
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_code   <= '0;
      r_dout   <= '0;
      r_sample <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_code   <= w_code_nxt;
      r_dout   <= w_dout_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns the variable; a missing
    // default in combinational logic infers a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (en) w_state_nxt = S_SAMPLE;
      S_SAMPLE: if (r_cnt == '0) w_state_nxt = S_CONV;
      S_CONV:   if (r_idx == '0) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = en ? S_SAMPLE : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_code_nxt   = r_code;
    w_dout_nxt   = r_dout;
    w_sample_nxt = 1'b0;
    w_valid_nxt  = 1'b0;
    w_busy_nxt   = 1'b0;
    w_trial      = r_code;
    w_keep       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_code_nxt = '0;
        if (en) begin
          w_sample_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
          w_cnt_nxt    = CNT_LOAD;
        end
      end
      S_SAMPLE: begin
        w_busy_nxt = 1'b1;
        if (r_cnt == '0) begin
          w_code_nxt = MIDSCALE;
          w_idx_nxt  = IDX_MSB;
        end else begin
          w_sample_nxt = 1'b1;
          w_cnt_nxt    = r_cnt - CW'(1);
        end
      end
      S_CONV: begin
        // Only a definite 1 keeps the trial bit; X/Z fall through as 0.
        if (comp) w_keep = 1'b1;
        w_trial[r_idx] = w_keep;
        if (r_idx != '0) begin
          w_trial[r_idx - IW'(1)] = 1'b1;
          w_idx_nxt  = r_idx - IW'(1);
          w_busy_nxt = 1'b1;
        end else begin
          w_dout_nxt  = to_dout(w_trial);
          w_valid_nxt = 1'b1;
        end
        w_code_nxt = w_trial;
      end
      default: w_code_nxt = '0;
    endcase
  end

  assign sample   = r_sample;
  assign dac_code = r_code;
  assign dout     = r_dout;
  assign valid    = r_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_sar_ctrl.sv
// Self-checking bench for sar_ctrl: timeline model of one conversion plus directed literal checks.
module tb_sar_ctrl;

  localparam int NBIT  = 8;
  localparam int NSAMP = 2;
  localparam int LAST  = NSAMP + NBIT + 1;

`ifdef SAR_TWOS_COMP_EN
  localparam int FLIP = 1 << (NBIT - 1);
`else
  localparam int FLIP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       comp = 1'b0;
  logic       sample;
  logic [7:0] dac_code;
  logic [7:0] dout;
  logic       valid;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit x_mode  = 1'b0;
  int vin     = 0;

  // Model: m_t is the position inside a conversion (0 = idle, 1..LAST).
  int m_t    = 0;
  int m_v    = 0;
  int m_dout = 0;

  sar_ctrl #(.NBIT(NBIT), .NSAMP(NSAMP)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .comp    (comp),
    .sample  (sample),
    .dac_code(dac_code),
    .dout    (dout),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Binary search on an ideal comparator: step k keeps the top k bits of the
  // input and tries the next bit.
  function automatic int exp_dac(input int t, input int v);
    int k;
    if (t >= NSAMP + 1 && t <= NSAMP + NBIT) begin
      k = t - NSAMP - 1;
      return ((v >> (NBIT - k)) << (NBIT - k)) | (1 << (NBIT - 1 - k));
    end
    if (t == LAST) return v;
    return 0;
  endfunction

  // Ideal comparator, or X when exercising undefined comparator output.
  always @(negedge clk) comp = x_mode ? 1'bx : (vin >= int'(dac_code));

  always @(posedge clk) begin
    if (!rst) begin
      m_t    = 0;
      m_dout = 0;
    end else if (m_t == 0) begin
      if (en) m_t = 1;
    end else if (m_t == LAST) begin
      m_t = en ? 1 : 0;
    end else begin
      m_t++;
      if (m_t == NSAMP + 1) m_v = x_mode ? 0 : vin;
      if (m_t == LAST) m_dout = m_v ^ FLIP;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sample", sample, int'(m_t >= 1 && m_t <= NSAMP));
      check("busy", busy, int'(m_t >= 1 && m_t <= NSAMP + NBIT));
      check("valid", valid, int'(m_t == LAST));
      check("dac_code", dac_code, exp_dac(m_t, m_v));
      check("dout", dout, m_dout);
    end
  end

  task automatic wait_valid(input int c0, output int cyc);
    cyc = c0;
    while (valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (valid !== 1'b1) check("valid_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sample"}, sample, 0);
    check({tag, "_dac"}, dac_code, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_one(input string name, input int v, input bit x, input int exp_dout);
    int cyc;
    vin = v;
    x_mode = x;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_valid(1, cyc);
    check({name, "_lat"}, cyc, LAST);
    check(name, dout, exp_dout);
    @(negedge clk);
    x_mode = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    int         samp_cnt;
    int         vcyc;
    int         got;
    logic [7:0] seq[$];
    logic [7:0] ref_seq[8];
    ref_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    // Reset held with en high, then released with en low.
    rst = 1'b0;
    en  = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    en  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("idle");

    // Single conversion of 0xA5 with a one-cycle en pulse.
    vin = 'hA5;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    samp_cnt = 0;
    vcyc = -1;
    got = -1;
    for (int c = 1; c <= 14; c++) begin
      if (sample === 1'b1) samp_cnt++;
      if (busy === 1'b1 && sample === 1'b0) seq.push_back(dac_code);
      if (valid === 1'b1 && vcyc < 0) begin
        vcyc = c;
        got = int'(dout);
      end
      @(negedge clk);
    end
    check("a5_sample_cycles", samp_cnt, 2);
    check("a5_valid_cycle", vcyc, 11);
    check("a5_seq_len", seq.size(), 8);
    for (int i = 0; i < 8 && i < seq.size(); i++) check("a5_seq", seq[i], ref_seq[i]);
    check("a5_dout", got, 'hA5 ^ FLIP);

    // Extremes and undefined comparator.
`ifdef SAR_TWOS_COMP_EN
    run_one("code80", 'h80, 1'b0, 'h00);
    run_one("code7f", 'h7F, 1'b0, 'hFF);
    run_one("compx", 'h00, 1'b1, 'h80);
`else
    run_one("code00", 'h00, 1'b0, 'h00);
    run_one("codeff", 'hFF, 1'b0, 'hFF);
    run_one("compx", 'hFF, 1'b1, 'h00);
`endif

    // Back-to-back conversions with en held high.
    vin = 'h3C;
    en = 1'b1;
    @(negedge clk);
    wait_valid(1, cyc);
    check("b2b_lat1", cyc, 11);
    check("b2b_dout1", dout, 'h3C ^ FLIP);
    vin = 'hC3;
    @(negedge clk);
    check("b2b_resample", sample, 1);
    wait_valid(1, cyc);
    check("b2b_period", cyc, 11);
    check("b2b_dout2", dout, 'hC3 ^ FLIP);
    en = 1'b0;
    @(negedge clk);
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_sample", sample, 0);
    repeat (2) @(negedge clk);

    // Reset while bit index 4 is on trial.
    vin = 'h5A;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_trial_code", dac_code, 'h50);
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_valid(1, cyc);
    check("post_rst_lat", cyc, 11);
    check("post_rst_dout", dout, 'h5A ^ FLIP);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
